// File: rtl/cpu_pkg.sv
// Shared definitions for the MIPS pipeline: MEM-stage FSM states, WB control
// bit positions and the MEM/WB pipeline register payload with its bubble value.
package cpu_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    REQ  = 1'b1
  } state_t;

  localparam int WB_REGWRITE = 0;
  localparam int WB_MEMTOREG = 1;

  typedef struct packed {
    logic [1:0]  wb;
    logic [31:0] mem_data;
    logic [31:0] alu_result;
    logic [4:0]  reg_dst;
  } mem_wb_t;

  // A bubble writes nothing back, so every field is simply zero.
  localparam mem_wb_t MEM_WB_BUBBLE = '0;

endpackage

// File: rtl/mem_wb_reg.sv
// MEM/WB pipeline register: each edge either captures the stage result or
// inserts a bubble.
module mem_wb_reg
  import cpu_pkg::*;
(
  input  logic    clk,
  input  logic    startin,
  input  logic    load,
  input  mem_wb_t d,
  output mem_wb_t q
);

  // Capture the new payload or squash to a bubble.
  // NOTE: sequential state is written with <= so every register samples the
  // pre-edge values, independent of statement order.
  always_ff @(posedge clk or posedge startin) begin
    if (startin) begin
      q <= MEM_WB_BUBBLE;
    end else if (load) begin
      q <= d;
    end else begin
      q <= MEM_WB_BUBBLE;
    end
  end

endmodule

// File: rtl/mem_access_stage.sv
// MEM stage of the 5-stage MIPS pipeline. Issues one data-memory access at a
// time over a req/ack bus, stalls upstream while it is outstanding, and feeds
// the MEM/WB register. Optional macro DMEM_TIMEOUT_EN adds an abort after
// TIMEOUT_CYCLES request cycles without ack, reported on sticky dmem_err.
module mem_access_stage
  import cpu_pkg::*;
#(
  parameter int ADDR_W         = 32,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic              clk,
  input  logic              startin,
  input  logic [1:0]        MEM_wb,
  input  logic              MEM_mem_read,
  input  logic              MEM_mem_write,
  input  logic [31:0]       MEM_alu_result,
  input  logic [31:0]       MEM_forward_b_mux_out,
  input  logic [4:0]        MEM_reg_dst_mux_out,
  output logic              dmem_req,
  output logic              dmem_we,
  output logic [ADDR_W-1:0] dmem_addr,
  output logic [31:0]       dmem_wdata,
  input  logic              dmem_ack,
  input  logic [31:0]       dmem_rdata,
  output logic              mem_stall,
  output logic [1:0]        WB_wb,
  output logic [31:0]       WB_mem_data,
  output logic [31:0]       WB_alu_result,
  output logic [4:0]        WB_reg_dst,
  output logic              dmem_err
);

  state_t  state;
  logic    mem_op;
  logic    is_load;
  logic    timeout_hit;
  logic    done;
  logic    wb_load;
  mem_wb_t wb_next;
  mem_wb_t wb_q;

  assign mem_op  = MEM_mem_read | MEM_mem_write;
  // A simultaneous read and write is handled as a store.
  assign is_load = MEM_mem_read & ~MEM_mem_write;
  assign done    = dmem_ack | timeout_hit;

  // Stall while an access is pending; release in the completing cycle so
  // EX/MEM advances on the same edge that retires the access.
  assign mem_stall = (state == IDLE) ? mem_op : ~done;

  // Sequence the bus: issue from IDLE, hold everything in REQ until done.
  always_ff @(posedge clk or posedge startin) begin
    if (startin) begin
      state      <= IDLE;
      dmem_req   <= 1'b0;
      dmem_we    <= 1'b0;
      dmem_addr  <= '0;
      dmem_wdata <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (mem_op) begin
            state      <= REQ;
            dmem_req   <= 1'b1;
            dmem_we    <= MEM_mem_write;
            dmem_addr  <= MEM_alu_result[ADDR_W-1:0];
            dmem_wdata <= MEM_forward_b_mux_out;
          end
        end
        REQ: begin
          if (done) begin
            state    <= IDLE;
            dmem_req <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef DMEM_TIMEOUT_EN
  localparam int CNT_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LIMIT = CNT_W'(TIMEOUT_CYCLES - 1);

  logic [CNT_W-1:0] to_cnt;

  assign timeout_hit = (state == REQ) && !dmem_ack && (to_cnt == CNT_LIMIT);

  // Count unacknowledged REQ cycles; flag an abort until the next reset.
  always_ff @(posedge clk or posedge startin) begin
    if (startin) begin
      to_cnt   <= '0;
      dmem_err <= 1'b0;
    end else begin
      if (state == IDLE && mem_op) begin
        to_cnt <= '0;
      end else if (state == REQ && !dmem_ack) begin
        to_cnt <= to_cnt + 1'b1;
      end
      if (timeout_hit) begin
        dmem_err <= 1'b1;
      end
    end
  end
`else
  assign timeout_hit = 1'b0;
  assign dmem_err    = 1'b0;
`endif

  // Build the MEM/WB payload and decide between a real result and a bubble.
  // NOTE: every signal assigned here gets a default first, so no path can
  // leave one unassigned and infer a latch.
  always_comb begin
    wb_load = 1'b0;
    wb_next = MEM_WB_BUBBLE;
    if (state == IDLE) begin
      wb_load = ~mem_op;
    end else begin
      wb_load = done;
    end
    wb_next.wb[WB_REGWRITE] = MEM_wb[WB_REGWRITE] & ~timeout_hit;
    wb_next.wb[WB_MEMTOREG] = MEM_wb[WB_MEMTOREG] & ~timeout_hit;
    wb_next.alu_result      = MEM_alu_result;
    wb_next.reg_dst         = MEM_reg_dst_mux_out;
    if (state == REQ && dmem_ack && is_load) begin
      wb_next.mem_data = dmem_rdata;
    end
  end

  mem_wb_reg u_mem_wb_reg (
    .clk     (clk),
    .startin (startin),
    .load    (wb_load),
    .d       (wb_next),
    .q       (wb_q)
  );

  assign WB_wb         = wb_q.wb;
  assign WB_mem_data   = wb_q.mem_data;
  assign WB_alu_result = wb_q.alu_result;
  assign WB_reg_dst    = wb_q.reg_dst;

endmodule

// File: tb/tb_mem_access_stage.sv
// Self-checking bench for mem_access_stage. Each instruction is modelled at
// transaction level: a non-memory op retires one edge later; a memory op
// issues on the next edge, waits for the chosen ack cycle, then retires.
module tb_mem_access_stage;

`ifdef DMEM_TIMEOUT_EN
  localparam int TO = 4;
`else
  localparam int TO = 255;
`endif

  logic        clk = 1'b0;
  logic        startin;
  logic [1:0]  MEM_wb;
  logic        MEM_mem_read;
  logic        MEM_mem_write;
  logic [31:0] MEM_alu_result;
  logic [31:0] MEM_forward_b_mux_out;
  logic [4:0]  MEM_reg_dst_mux_out;
  logic        dmem_req;
  logic        dmem_we;
  logic [31:0] dmem_addr;
  logic [31:0] dmem_wdata;
  logic        dmem_ack;
  logic [31:0] dmem_rdata;
  logic        mem_stall;
  logic [1:0]  WB_wb;
  logic [31:0] WB_mem_data;
  logic [31:0] WB_alu_result;
  logic [4:0]  WB_reg_dst;
  logic        dmem_err;

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  mem_access_stage #(.ADDR_W(32), .TIMEOUT_CYCLES(TO)) dut (
    .clk                   (clk),
    .startin               (startin),
    .MEM_wb                (MEM_wb),
    .MEM_mem_read          (MEM_mem_read),
    .MEM_mem_write         (MEM_mem_write),
    .MEM_alu_result        (MEM_alu_result),
    .MEM_forward_b_mux_out (MEM_forward_b_mux_out),
    .MEM_reg_dst_mux_out   (MEM_reg_dst_mux_out),
    .dmem_req              (dmem_req),
    .dmem_we               (dmem_we),
    .dmem_addr             (dmem_addr),
    .dmem_wdata            (dmem_wdata),
    .dmem_ack              (dmem_ack),
    .dmem_rdata            (dmem_rdata),
    .mem_stall             (mem_stall),
    .WB_wb                 (WB_wb),
    .WB_mem_data           (WB_mem_data),
    .WB_alu_result         (WB_alu_result),
    .WB_reg_dst            (WB_reg_dst),
    .dmem_err              (dmem_err)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic check_bubble(input string tag);
    check({tag, "_wb"},   {30'd0, WB_wb}, 32'd0);
    check({tag, "_mdat"}, WB_mem_data, 32'd0);
    check({tag, "_alu"},  WB_alu_result, 32'd0);
    check({tag, "_rd"},   {27'd0, WB_reg_dst}, 32'd0);
  endtask

  task automatic drive(input logic [1:0] wb, input logic [4:0] rd, input logic [31:0] alu,
                       input logic [31:0] wdat, input logic rd_en, input logic wr_en);
    MEM_wb                = wb;
    MEM_reg_dst_mux_out   = rd;
    MEM_alu_result        = alu;
    MEM_forward_b_mux_out = wdat;
    MEM_mem_read          = rd_en;
    MEM_mem_write         = wr_en;
  endtask

  // One instruction from an IDLE cycle to retirement; k = REQ cycle carrying ack.
  task automatic run_op(input logic [1:0] wb, input logic [4:0] rd, input logic [31:0] alu,
                        input logic [31:0] wdat, input logic rd_en, input logic wr_en,
                        input int k);
    logic        mem;
    logic        is_load;
    logic [31:0] rdat;
    mem     = rd_en | wr_en;
    is_load = rd_en & ~wr_en;
    drive(wb, rd, alu, wdat, rd_en, wr_en);
    dmem_ack = 1'b0;
    #1 check("stall_idle", {31'd0, mem_stall}, {31'd0, mem});
    @(negedge clk);
    if (!mem) begin
      check("alu_wb",   {30'd0, WB_wb}, {30'd0, wb});
      check("alu_res",  WB_alu_result, alu);
      check("alu_rd",   {27'd0, WB_reg_dst}, {27'd0, rd});
      check("alu_mdat", WB_mem_data, 32'd0);
      check("alu_req",  {31'd0, dmem_req}, 32'd0);
      return;
    end
    check_bubble("issue");
    check("issue_req",  {31'd0, dmem_req}, 32'd1);
    check("issue_we",   {31'd0, dmem_we}, {31'd0, wr_en});
    check("issue_addr", dmem_addr, alu);
    check("issue_wdat", dmem_wdata, wdat);
    for (int i = 1; i <= k; i++) begin
      rdat       = $urandom;
      dmem_rdata = rdat;
      dmem_ack   = (i == k);
      #1 check("stall_req", {31'd0, mem_stall}, {31'd0, (i < k)});
      @(negedge clk);
      if (i < k) begin
        check_bubble("wait");
        check("wait_req",  {31'd0, dmem_req}, 32'd1);
        check("wait_we",   {31'd0, dmem_we}, {31'd0, wr_en});
        check("wait_addr", dmem_addr, alu);
        check("wait_wdat", dmem_wdata, wdat);
      end else begin
        check("done_req",  {31'd0, dmem_req}, 32'd0);
        check("done_wb",   {30'd0, WB_wb}, {30'd0, wb});
        check("done_mdat", WB_mem_data, is_load ? rdat : 32'd0);
        check("done_alu",  WB_alu_result, alu);
        check("done_rd",   {27'd0, WB_reg_dst}, {27'd0, rd});
        check("done_err",  {31'd0, dmem_err}, 32'd0);
      end
    end
    dmem_ack = 1'b0;
  endtask

  initial begin
    startin  = 1'b1;
    dmem_ack = 1'b0;
    dmem_rdata = 32'd0;
    drive(2'b00, 5'd0, 32'd0, 32'd0, 1'b0, 1'b0);
    repeat (2) @(negedge clk);
    check_bubble("rst");
    check("rst_req",   {31'd0, dmem_req}, 32'd0);
    check("rst_we",    {31'd0, dmem_we}, 32'd0);
    check("rst_addr",  dmem_addr, 32'd0);
    check("rst_wdata", dmem_wdata, 32'd0);
    check("rst_err",   {31'd0, dmem_err}, 32'd0);
    startin = 1'b0;

    // Directed cases from the plan.
    run_op(2'b01, 5'd5, 32'h0000_0010, 32'h0, 1'b0, 1'b0, 1);
    run_op(2'b11, 5'd7, 32'h0000_0100, 32'h0, 1'b1, 1'b0, 1);
    run_op(2'b00, 5'd0, 32'h0000_0040, 32'h1234_5678, 1'b0, 1'b1, 4);
    run_op(2'b11, 5'd9, 32'h0000_0200, 32'h0, 1'b1, 1'b0, 2);
    run_op(2'b00, 5'd3, 32'h0000_0204, 32'hCAFE_F00D, 1'b0, 1'b1, 1);
    run_op(2'b11, 5'd4, 32'h0000_0300, 32'hA5A5_5A5A, 1'b1, 1'b1, 2);

    // Randomized instruction stream.
    for (int n = 0; n < 24; n++) begin
      int kind;
      kind = $urandom_range(0, 3);
      run_op(2'($urandom), 5'($urandom), $urandom, $urandom,
             (kind == 1) || (kind == 3), (kind == 2) || (kind == 3),
             $urandom_range(1, 3));
    end

    // Asynchronous reset in the middle of a REQ cycle abandons the access.
    drive(2'b11, 5'd6, 32'h0000_0800, 32'h0, 1'b1, 1'b0);
    @(negedge clk);
    check("pre_rst_req", {31'd0, dmem_req}, 32'd1);
    #2 startin = 1'b1;
    #1 check("arst_req", {31'd0, dmem_req}, 32'd0);
    check_bubble("arst");
    startin    = 1'b0;
    drive(2'b01, 5'd12, 32'h0000_0ABC, 32'h0, 1'b0, 1'b0);
    dmem_ack   = 1'b1;
    dmem_rdata = 32'hFFFF_FFFF;
    @(negedge clk);
    check("post_rst_req",  {31'd0, dmem_req}, 32'd0);
    check("post_rst_wb",   {30'd0, WB_wb}, 32'd1);
    check("post_rst_alu",  WB_alu_result, 32'h0000_0ABC);
    check("post_rst_rd",   {27'd0, WB_reg_dst}, 32'd12);
    check("post_rst_mdat", WB_mem_data, 32'd0);
    dmem_ack = 1'b0;

`ifdef DMEM_TIMEOUT_EN
    // Ack in the limit cycle wins.
    run_op(2'b11, 5'd8, 32'h0000_0500, 32'h0, 1'b1, 1'b0, TO);
    // No ack at all: abort after TO request cycles.
    drive(2'b11, 5'd10, 32'h0000_0600, 32'h0, 1'b1, 1'b0);
    @(negedge clk);
    for (int i = 1; i <= TO; i++) begin
      dmem_rdata = $urandom;
      #1 check("to_stall", {31'd0, mem_stall}, {31'd0, (i < TO)});
      @(negedge clk);
      if (i < TO) begin
        check("to_wait_err", {31'd0, dmem_err}, 32'd0);
        check("to_wait_req", {31'd0, dmem_req}, 32'd1);
      end else begin
        check("to_err",  {31'd0, dmem_err}, 32'd1);
        check("to_wb",   {30'd0, WB_wb}, 32'd0);
        check("to_mdat", WB_mem_data, 32'd0);
        check("to_req",  {31'd0, dmem_req}, 32'd0);
      end
    end
    drive(2'b01, 5'd2, 32'h0000_0077, 32'h0, 1'b0, 1'b0);
    @(negedge clk);
    check("to_sticky", {31'd0, dmem_err}, 32'd1);
    check("to_next_alu", WB_alu_result, 32'h0000_0077);
    startin = 1'b1;
    #1 check("to_clear", {31'd0, dmem_err}, 32'd0);
    startin = 1'b0;
`else
    check("err_tied", {31'd0, dmem_err}, 32'd0);
`endif

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/mem_access_stage.md
Name: mem_access_stage

Overview:
- MEM stage of the 5-stage pipelined MIPS core. Sits directly downstream of the EX/MEM pipeline register and consumes its outputs.
- Performs data-memory loads and stores over a request/acknowledge bus with variable latency.
- Stalls the upstream pipeline while an access is outstanding, and drives the MEM/WB pipeline register feeding writeback.

Parameters:
- ADDR_W, 32, data-memory byte-address width (low ADDR_W bits of MEM_alu_result).
- TIMEOUT_CYCLES, 255, maximum REQ-state cycles before abort (used only with DMEM_TIMEOUT_EN).

Ports:
- clk  in  1  pipeline clock, rising edge.
- startin  in  1  reset, asynchronous, active-high.
- MEM_wb  in  2  writeback control from EX/MEM; bit0 = RegWrite, bit1 = MemToReg.
- MEM_mem_read  in  1  load request.
- MEM_mem_write  in  1  store request.
- MEM_alu_result  in  32  effective address, or ALU result for non-memory ops.
- MEM_forward_b_mux_out  in  32  store data.
- MEM_reg_dst_mux_out  in  5  destination register.
- dmem_req  out  1  memory request, registered.
- dmem_we  out  1  1 = store, 0 = load; valid while dmem_req.
- dmem_addr  out  ADDR_W  access address; valid while dmem_req.
- dmem_wdata  out  32  store data; valid while dmem_req.
- dmem_ack  in  1  access complete; ignored unless in REQ.
- dmem_rdata  in  32  load data; valid with dmem_ack.
- mem_stall  out  1  combinational; freezes PC, IF/ID, ID/EX, EX/MEM.
- WB_wb  out  2  writeback control.
- WB_mem_data  out  32  load data.
- WB_alu_result  out  32  forwarded ALU result.
- WB_reg_dst  out  5  destination register.
- dmem_err  out  1  sticky timeout flag (DMEM_TIMEOUT_EN only; tie 0 otherwise).

Behaviour:
- Reset (startin=1, asynchronous):
  - FSM goes to IDLE.
  - dmem_req, dmem_we, dmem_addr, dmem_wdata = 0.
  - WB_wb, WB_mem_data, WB_alu_result, WB_reg_dst = 0.
  - dmem_err = 0; timeout counter = 0.
  - Reset mid-access abandons the request with no completion.
- FSM states: IDLE, REQ.
- IDLE, no memory op (MEM_mem_read=MEM_mem_write=0):
  - mem_stall = 0.
  - Next edge loads MEM/WB: WB_wb=MEM_wb, WB_alu_result=MEM_alu_result, WB_reg_dst=MEM_reg_dst_mux_out, WB_mem_data=0.
  - Latency 1 cycle.
- IDLE, memory op present:
  - mem_stall = 1.
  - Next edge: latch dmem_addr, dmem_wdata, dmem_we (=MEM_mem_write); set dmem_req=1; go to REQ.
  - Same edge loads a MEM/WB bubble: WB_wb=0, other WB outputs 0.
- Read and write both asserted: treated as a store (write wins).
- REQ, dmem_ack=0:
  - mem_stall = 1; dmem_req and all bus outputs held stable.
  - MEM/WB loads a bubble each cycle.
- REQ, dmem_ack=1:
  - mem_stall = 0 in that cycle.
  - Next edge loads MEM/WB from the held EX/MEM inputs; WB_mem_data = dmem_rdata for a load, 0 for a store.
  - Same edge: dmem_req=0, go to IDLE.
  - EX/MEM advances on that same edge, so the next instruction is evaluated in IDLE the following cycle.
  - Minimum load/store latency: 2 cycles.
- Back-to-back memory ops: each pays one IDLE cycle plus the REQ cycles; no request pipelining.
- EX/MEM inputs are guaranteed stable while mem_stall=1; the block does not re-sample them for address or data.

Optional Feature:
- Macro: DMEM_TIMEOUT_EN.
- Defined:
  - Counter increments each REQ cycle without ack; cleared on entry to REQ.
  - When the counter reaches TIMEOUT_CYCLES-1 with no ack: treat as completion with dmem_rdata forced to 0, WB_wb forced to 0 (no writeback), dmem_err set sticky until startin, FSM returns to IDLE.
  - An ack in the same cycle as the limit wins: normal completion, no error.
- Undefined: no counter; REQ waits indefinitely; dmem_err constant 0.

Decomposition:
- Shared package cpu_pkg holds:
  - state enum (IDLE=1'b0, REQ=1'b1);
  - WB control bit indices (WB_REGWRITE=0, WB_MEMTOREG=1);
  - bubble constant for MEM/WB.
- One natural sub-module: mem_wb_reg, the MEM/WB pipeline register, with a load-or-bubble select. The FSM and bus driver stay in the top module.

Test Plan:
- ALU op: wb=2'b01, alu=0x0000_0010, rd=5, no mem op -> next edge WB_wb=01, WB_alu_result=0x10, WB_reg_dst=5, mem_stall never 1.
- Load, ack on first REQ cycle: read=1, addr=0x100, dmem_rdata=0xDEADBEEF -> mem_stall=1 for 1 cycle, dmem_req=1 for 1 cycle, WB_mem_data=0xDEADBEEF two edges after issue, one bubble (WB_wb=0) in between.
- Store, ack after 3 REQ cycles: write=1, addr=0x40, data=0x12345678 -> dmem_we=1 and addr/wdata stable all 3 cycles, mem_stall=1 for 4 cycles, WB_mem_data=0.
- Back-to-back load then store -> two separate requests, dmem_req deasserted for at least one cycle between them, correct order and data.
- startin pulsed during REQ (async, mid-cycle) -> dmem_req and all WB outputs 0 immediately, FSM in IDLE; a subsequent ack is ignored.
- DMEM_TIMEOUT_EN, TIMEOUT_CYCLES=4, no ack -> after 4 REQ cycles: dmem_err=1, WB_wb=0, stall released. Repeat with ack on the 4th cycle -> normal completion, dmem_err=0.
